// File: rtl/cpu_clk_pkg.sv
// Shared definitions for the CPU clock-enable controller: mode encodings,
// FSM state enum and the mode-to-state mapping.
package cpu_clk_pkg;

   localparam logic [1:0] MODE_HALT = 2'b00;
   localparam logic [1:0] MODE_RUN  = 2'b01;
   localparam logic [1:0] MODE_SLOW = 2'b10;
   localparam logic [1:0] MODE_STEP = 2'b11;

   typedef enum logic [1:0] {
      S_HALT = 2'd0,
      S_RUN  = 2'd1,
      S_SLOW = 2'd2,
      S_STEP = 2'd3
   } state_t;

   // Each mode selects exactly one state; unknown codes fall back to halt.
   function automatic state_t mode_to_state(input logic [1:0] m);
      state_t s;
      case (m)
         MODE_HALT: s = S_HALT;
         MODE_RUN:  s = S_RUN;
         MODE_SLOW: s = S_SLOW;
         MODE_STEP: s = S_STEP;
         default:   s = S_HALT;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// Step-button conditioning: 2-flop synchronizer, stability counter and a
// one-cycle pulse on each debounced 0->1 change.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk_in,
   input  logic rst,
   input  logic btn_in,
   output logic db_rise
);

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_r;
   logic          sync_btn_r;
   logic          db_level_r;
   logic          db_rise_r;
   logic [CW-1:0] cnt_r;

   // Bring the raw asynchronous button into the clk_in domain.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         sync1_r    <= 1'b0;
         sync_btn_r <= 1'b0;
      end else begin
         sync1_r    <= btn_in;
         sync_btn_r <= sync1_r;
      end
   end

   // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles;
   // the rise pulse is registered together with the level change.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         cnt_r      <= {CW{1'b0}};
         db_level_r <= 1'b0;
         db_rise_r  <= 1'b0;
      end else if (sync_btn_r == db_level_r) begin
         cnt_r     <= {CW{1'b0}};
         db_rise_r <= 1'b0;
      end else if (cnt_r == CNT_LAST) begin
         cnt_r      <= {CW{1'b0}};
         db_level_r <= sync_btn_r;
         db_rise_r  <= sync_btn_r;
      end else begin
         cnt_r     <= cnt_r + CW'(1);
         db_rise_r <= 1'b0;
      end
   end

   assign db_rise = db_rise_r;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable controller: turns mode, the sampled slow clock and the
// debounced step button into a registered one-cycle cpu_ce plus a pulse count.
// Optional breakpoint halt is built when CPU_CLK_BREAK_EN is defined.
module cpu_clk_ctrl #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 16,
   parameter int PC_W            = 32
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             slow_clk_in,
   input  logic             step_btn,
   input  logic [1:0]       mode,
   output logic             cpu_ce,
   output logic             halted,
   output logic [CNT_W-1:0] step_count,
   input  logic [PC_W-1:0]  pc_in,
   input  logic [PC_W-1:0]  bp_addr,
   input  logic             bp_en,
   output logic             brk_hit
);

   import cpu_clk_pkg::*;

   state_t           state_r;
   state_t           next_state_s;
   state_t           mode_state_s;
   logic             cpu_ce_r;
   logic             halted_r;
   logic [CNT_W-1:0] step_count_r;
   logic             slow_q_r;
   logic             slow_rise_s;
   logic             db_rise_s;
   logic             ce_raw_s;
   logic             ce_next_s;
   logic             entry_gate_s;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .clk_in (clk_in),
      .rst    (rst),
      .btn_in (step_btn),
      .db_rise(db_rise_s)
   );

   // Delay the divided clock by one cycle to find its rising edges.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         slow_q_r <= 1'b0;
      end else begin
         slow_q_r <= slow_clk_in;
      end
   end

   assign slow_rise_s  = slow_clk_in & ~slow_q_r;
   assign mode_state_s = mode_to_state(mode);

   // An edge that lands on the mode change into SLOW/STEP is dropped.
   assign entry_gate_s = (mode_state_s != state_r) &&
                         ((mode_state_s == S_SLOW) || (mode_state_s == S_STEP));

   // Enable request from the current state; events seen in other states are lost.
   always_comb begin
      ce_raw_s = 1'b0;
      case (state_r)
         S_HALT:  ce_raw_s = 1'b0;
         S_RUN:   ce_raw_s = 1'b1;
         S_SLOW:  ce_raw_s = slow_rise_s;
         S_STEP:  ce_raw_s = db_rise_s;
         default: ce_raw_s = 1'b0;
      endcase
   end

`ifdef CPU_CLK_BREAK_EN
   logic brk_hit_r;
   logic brk_next_s;
   logic bp_match_s;

   assign bp_match_s = bp_en && (pc_in == bp_addr) && (state_r != S_HALT);

   // Breakpoint match forces halt; the flag holds halt until mode 00 is seen.
   always_comb begin
      next_state_s = mode_state_s;
      ce_next_s    = ce_raw_s & ~entry_gate_s;
      brk_next_s   = 1'b0;
      if (bp_match_s) begin
         next_state_s = S_HALT;
         ce_next_s    = 1'b0;
         brk_next_s   = 1'b1;
      end else if (brk_hit_r) begin
         next_state_s = S_HALT;
         brk_next_s   = (mode != MODE_HALT);
      end else begin
         brk_next_s   = 1'b0;
      end
   end

   // Sticky breakpoint flag.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         brk_hit_r <= 1'b0;
      end else begin
         brk_hit_r <= brk_next_s;
      end
   end

   assign brk_hit = brk_hit_r;
`else
   logic unused_bp_s;
   assign unused_bp_s  = ^{pc_in, bp_addr, bp_en};
   assign next_state_s = mode_state_s;
   assign ce_next_s    = ce_raw_s & ~entry_gate_s;
   assign brk_hit      = 1'b0;
`endif

   // State register, registered enable, halted flag and wrapping pulse count.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_r      <= S_HALT;
         cpu_ce_r     <= 1'b0;
         halted_r     <= 1'b1;
         step_count_r <= {CNT_W{1'b0}};
      end else begin
         state_r      <= next_state_s;
         cpu_ce_r     <= ce_next_s;
         halted_r     <= (next_state_s == S_HALT);
         step_count_r <= step_count_r + {{(CNT_W-1){1'b0}}, cpu_ce_r};
      end
   end

   assign cpu_ce     = cpu_ce_r;
   assign halted     = halted_r;
   assign step_count = step_count_r;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl: directed scenarios plus random
// stimulus, every cycle compared against a cycle-level behavioural model.
module tb_cpu_clk_ctrl;

   localparam int DEB   = 4;
   localparam int CNT_W = 4;
   localparam int PC_W  = 32;

   logic             clk_in = 1'b0;
   logic             rst;
   logic             slow_clk_in;
   logic             step_btn;
   logic [1:0]       mode;
   logic             cpu_ce;
   logic             halted;
   logic [CNT_W-1:0] step_count;
   logic [PC_W-1:0]  pc_in;
   logic [PC_W-1:0]  bp_addr;
   logic             bp_en;
   logic             brk_hit;

   int n_checks = 0;
   int n_pass   = 0;
   int ce_seen  = 0;

   // model state: mode-level state (0..3), outputs, button history, slow history
   int m_state, m_cnt, m_run;
   bit m_ce, m_halted, m_brk;
   bit m_s1, m_s2, m_level, m_pend, m_slow_prev;

   cpu_clk_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(CNT_W), .PC_W(PC_W)) dut (
      .clk_in(clk_in), .rst(rst), .slow_clk_in(slow_clk_in), .step_btn(step_btn),
      .mode(mode), .cpu_ce(cpu_ce), .halted(halted), .step_count(step_count),
      .pc_in(pc_in), .bp_addr(bp_addr), .bp_en(bp_en), .brk_hit(brk_hit)
   );

   always #5 clk_in = ~clk_in;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      m_state = 0; m_cnt = 0; m_run = 0;
      m_ce = 1'b0; m_halted = 1'b1; m_brk = 1'b0;
      m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0; m_pend = 1'b0; m_slow_prev = 1'b0;
   endtask

   // Advance the model by one clk_in edge using the inputs currently applied.
   task automatic model_edge();
      bit slow_ev, step_ev, ce_n, brk_n;
      int ns;
      slow_ev = slow_clk_in & ~m_slow_prev;
      step_ev = m_pend;
      ns      = int'(mode);
      brk_n   = 1'b0;
      case (m_state)
         1: ce_n = 1'b1;
         2: ce_n = slow_ev;
         3: ce_n = step_ev;
         default: ce_n = 1'b0;
      endcase
      if (ns != m_state && ns >= 2) ce_n = 1'b0;
`ifdef CPU_CLK_BREAK_EN
      if (bp_en && pc_in == bp_addr && m_state != 0) begin
         ns = 0; ce_n = 1'b0; brk_n = 1'b1;
      end else if (m_brk) begin
         ns = 0; brk_n = (mode != 2'b00);
      end
`endif
      m_cnt    = (m_cnt + int'(m_ce)) % (1 << CNT_W);
      m_ce     = ce_n;
      m_state  = ns;
      m_halted = (ns == 0);
      m_brk    = brk_n;
      // debounce: level follows after DEB consecutive differing synchronized samples
      m_pend = 1'b0;
      if (m_s2 != m_level) begin
         m_run++;
         if (m_run == DEB) begin
            m_level = m_s2; m_run = 0; m_pend = m_s2;
         end
      end else begin
         m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = step_btn;
      m_slow_prev = slow_clk_in;
   endtask

   task automatic step_cycle();
      model_edge();
      @(posedge clk_in);
      #1;
      if (cpu_ce === 1'b1) ce_seen++;
      check_val("cpu_ce", 32'(cpu_ce), 32'(m_ce));
      check_val("halted", 32'(halted), 32'(m_halted));
      check_val("step_count", 32'(step_count), 32'(m_cnt));
      check_val("brk_hit", 32'(brk_hit), 32'(m_brk));
   endtask

   initial begin
      int lat;
      rst = 1'b1; slow_clk_in = 1'b0; step_btn = 1'b0; mode = 2'b00;
      pc_in = '0; bp_addr = '0; bp_en = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      check_val("rst_ce", 32'(cpu_ce), 32'd0);
      check_val("rst_halted", 32'(halted), 32'd1);
      check_val("rst_cnt", 32'(step_count), 32'd0);
      check_val("rst_brk", 32'(brk_hit), 32'd0);
      rst = 1'b0;
      model_reset();

      // RUN for 10 cycles
      mode = 2'b01;
      repeat (10) step_cycle();
      mode = 2'b00;
      repeat (3) step_cycle();
      check_val("run10_cnt", 32'(step_count), 32'd10);

      // SLOW with three rising edges of the divided clock
      mode = 2'b10;
      step_cycle();
      ce_seen = 0;
      for (int i = 0; i < 3; i++) begin
         slow_clk_in = 1'b1; repeat (8) step_cycle();
         slow_clk_in = 1'b0; repeat (8) step_cycle();
      end
      check_val("slow_pulses", 32'(ce_seen), 32'd3);
      check_val("slow_cnt", 32'(step_count), 32'd13);

      // STEP: glitches then a long press
      mode = 2'b11;
      step_cycle();
      ce_seen = 0;
      step_btn = 1'b1; step_cycle();
      step_btn = 1'b0; repeat (3) step_cycle();
      step_btn = 1'b1; repeat (2) step_cycle();
      step_btn = 1'b0; repeat (5) step_cycle();
      check_val("glitch_pulses", 32'(ce_seen), 32'd0);
      lat = 0;
      step_btn = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         step_cycle();
         if (cpu_ce === 1'b1 && lat == 0) lat = k;
      end
      step_btn = 1'b0;
      repeat (10) step_cycle();
      check_val("step_pulses", 32'(ce_seen), 32'd1);
      check_val("step_latency", 32'(lat), 32'd7);
      check_val("step_cnt", 32'(step_count), 32'd14);

      // Counter wrap: 14 + 20 pulses in a 4-bit counter
      mode = 2'b01;
      repeat (20) step_cycle();
      mode = 2'b00;
      repeat (3) step_cycle();
      check_val("wrap_cnt", 32'(step_count), 32'd2);

      // Asynchronous reset in the middle of RUN
      mode = 2'b01;
      repeat (4) step_cycle();
      #2 rst = 1'b1;
      #1;
      check_val("arst_ce", 32'(cpu_ce), 32'd0);
      check_val("arst_cnt", 32'(step_count), 32'd0);
      check_val("arst_halted", 32'(halted), 32'd1);
      @(posedge clk_in);
      @(posedge clk_in);
      #1;
      rst = 1'b0;
      model_reset();
      repeat (4) step_cycle();
      mode = 2'b00;
      repeat (2) step_cycle();

`ifdef CPU_CLK_BREAK_EN
      // Breakpoint hit while sweeping the PC in RUN
      bp_addr = 32'h0000_0010; bp_en = 1'b1; pc_in = 32'h0; mode = 2'b01;
      repeat (2) step_cycle();
      for (int pc = 0; pc <= 32'h14; pc += 4) begin
         pc_in = 32'(pc);
         step_cycle();
      end
      check_val("bp_brk", 32'(brk_hit), 32'd1);
      check_val("bp_halted", 32'(halted), 32'd1);
      mode = 2'b00;
      step_cycle();
      check_val("bp_clear", 32'(brk_hit), 32'd0);
      mode = 2'b01;
      repeat (2) step_cycle();
      check_val("bp_resume", 32'(cpu_ce), 32'd1);
      bp_en = 1'b0; mode = 2'b00;
      step_cycle();
`endif

      // Random stimulus
      bp_addr = 32'd2;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 5) == 0) slow_clk_in = ~slow_clk_in;
         if ($urandom_range(0, 7) == 0) step_btn = ~step_btn;
         bp_en = ($urandom_range(0, 15) == 0);
         pc_in = 32'($urandom_range(0, 3));
         step_cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
